mda_motor_ramp_scheduler: RTL and testbench

Controller sitting between the host Avalon slave and the 8-channel motor control register file (duty registers at addr 8..15, enable/control at addr 0..7, PWM period at addr 16).
- Accepts per-motor target duty and enable from the host.
- On a fixed tick, slews each motor's programmed duty toward its target by a bounded step, issuing single-cycle register writes in a round-robin scan.
- Enforces enable/disable ordering, a power-up init sequence, and a command watchdog that ramps all motors down on host silence.

---
 rtl/mda_motor_ramp_scheduler_pkg.sv | 24 ++
 rtl/mda_ramp_step.sv | 32 +++
 rtl/mda_motor_ramp_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_mda_motor_ramp_scheduler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mda_motor_ramp_scheduler_pkg.sv
// Shared constants and state encoding for the motor ramp scheduler.
// Addresses follow the motor control register file layout.
package mda_motor_ramp_scheduler_pkg;

  localparam int PERIOD_LENGTH = 16;
  localparam int NUM_MOTORS    = 8;
  localparam int INIT_WRITES   = 17;

  localparam logic [4:0] CTRL_BASE   = 5'd0;
  localparam logic [4:0] DUTY_BASE   = 5'd8;
  localparam logic [4:0] PERIOD_ADDR = 5'd16;

  localparam logic [3:0] HOST_GLOBAL = 4'd8;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SCAN_EN,
    ST_SCAN_DUTY,
    ST_SCAN_DIS,
    ST_NEXT
  } state_e;

endpackage

// File: rtl/mda_ramp_step.sv
// Bounded slew of one duty value toward its target.
// Magnitude is compared before stepping, so the result can never wrap.
module mda_ramp_step #(
  parameter int DUTY_W = 16,
  parameter int STEP   = 16
) (
  input  logic [DUTY_W-1:0] cur_i,
  input  logic [DUTY_W-1:0] eff_i,
  output logic [DUTY_W-1:0] next_o,
  output logic              equal_o
);

  localparam int              EXT_W    = DUTY_W + 1;
  localparam logic [EXT_W-1:0] STEP_EXT = EXT_W'(STEP);

  logic             rising;
  logic [DUTY_W-1:0] diff;

  always_comb begin
    equal_o = (cur_i == eff_i);
    rising  = (eff_i > cur_i);
    diff    = rising ? (eff_i - cur_i) : (cur_i - eff_i);
    if ({1'b0, diff} <= STEP_EXT) begin
      next_o = eff_i;
    end else if (rising) begin
      next_o = cur_i + STEP_EXT[DUTY_W-1:0];
    end else begin
      next_o = cur_i - STEP_EXT[DUTY_W-1:0];
    end
  end

endmodule

// File: rtl/mda_motor_ramp_scheduler.sv
// Host-facing ramp scheduler: init sequence, periodic round-robin duty slewing
// and a command watchdog, all driving single-cycle motor control register writes.
module mda_motor_ramp_scheduler
  import mda_motor_ramp_scheduler_pkg::*;
#(
  parameter int DUTY_W      = PERIOD_LENGTH,
  parameter int STEP        = 16,
  parameter int RAMP_DIV    = 50000,
  parameter int WDT_CYCLES  = 50000000,
  parameter int PERIOD_INIT = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        host_chipselect,
  input  logic        host_write,
  input  logic [3:0]  host_addr,
  input  logic [31:0] host_writedata,
  output logic        mc_chipselect,
  output logic        mc_write,
  output logic [4:0]  mc_addr,
  output logic [31:0] mc_writedata,
  output logic        init_done,
  output logic        busy,
  output logic        fault,
  output logic        overrun
);

  localparam int TICK_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int WDT_W  = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RAMP_DIV - 1);
  localparam logic [WDT_W-1:0]  WDT_LAST  = WDT_W'(WDT_CYCLES - 1);

  state_e                state_q;
  logic [2:0]            motor_q;
  logic [4:0]            init_cnt_q;
  logic [DUTY_W-1:0]     cur_duty_q [NUM_MOTORS];
  logic [NUM_MOTORS-1:0] cur_en_q;
  logic [DUTY_W-1:0]     tgt_duty_q [NUM_MOTORS];
  logic [NUM_MOTORS-1:0] tgt_en_q;
  logic                  global_en_q;
  logic                  pending_q;
  logic                  fault_q, fault_d;
  logic                  overrun_q, overrun_d;
  logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [WDT_W-1:0]      wdt_cnt_q, wdt_cnt_d;

  logic                  mc_cs_q, mc_write_q, init_done_q, busy_q;
  logic [4:0]            mc_addr_q;
  logic [31:0]           mc_data_q;

  logic                  host_wr, flag_clear, tick, wdt_expire, scanning;
  logic [DUTY_W-1:0]     cur_duty, eff_duty, step_next;
  logic                  step_equal;
  logic                  unused_host_bits;

  assign host_wr          = host_chipselect & host_write;
  assign flag_clear       = host_wr && (host_addr == HOST_GLOBAL) && host_writedata[1];
  assign tick             = init_done_q && (tick_cnt_q == TICK_LAST);
  assign wdt_expire       = init_done_q && !host_wr && (wdt_cnt_q == WDT_LAST);
  assign scanning         = state_q inside {ST_SCAN_EN, ST_SCAN_DUTY, ST_SCAN_DIS, ST_NEXT};
  assign unused_host_bits = ^host_writedata;

  assign cur_duty = cur_duty_q[motor_q];
  assign eff_duty = (fault_q || !global_en_q || !tgt_en_q[motor_q]) ? '0 : tgt_duty_q[motor_q];

  mda_ramp_step #(
    .DUTY_W (DUTY_W),
    .STEP   (STEP)
  ) u_ramp_step (
    .cur_i   (cur_duty),
    .eff_i   (eff_duty),
    .next_o  (step_next),
    .equal_o (step_equal)
  );

  // A host write in the expiry cycle reloads the watchdog, so fault stays clear.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    wdt_cnt_d  = wdt_cnt_q;
    fault_d    = fault_q;
    overrun_d  = overrun_q;
    if (init_done_q) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end
    if (host_wr) begin
      wdt_cnt_d = '0;
    end else if (init_done_q && (wdt_cnt_q != WDT_LAST)) begin
      wdt_cnt_d = wdt_cnt_q + 1'b1;
    end
    if (wdt_expire) fault_d = 1'b1;
    if (tick && pending_q && scanning) overrun_d = 1'b1;
    if (flag_clear) begin
      fault_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q  <= '0;
      wdt_cnt_q   <= '0;
      fault_q     <= 1'b0;
      overrun_q   <= 1'b0;
      global_en_q <= 1'b0;
      tgt_en_q    <= '0;
      for (int m = 0; m < NUM_MOTORS; m++) tgt_duty_q[m] <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      wdt_cnt_q  <= wdt_cnt_d;
      fault_q    <= fault_d;
      overrun_q  <= overrun_d;
      if (host_wr && !host_addr[3] && !fault_q) begin
        tgt_duty_q[host_addr[2:0]] <= host_writedata[DUTY_W-1:0];
        tgt_en_q[host_addr[2:0]]   <= host_writedata[16];
      end
      if (host_wr && (host_addr == HOST_GLOBAL)) begin
        global_en_q <= host_writedata[0];
      end
    end
  end

  // Each motor visit is enable, duty step, disable: one optional write per state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      motor_q     <= '0;
      init_cnt_q  <= '0;
      pending_q   <= 1'b0;
      cur_en_q    <= '0;
      for (int m = 0; m < NUM_MOTORS; m++) cur_duty_q[m] <= '0;
      mc_cs_q     <= 1'b0;
      mc_write_q  <= 1'b0;
      mc_addr_q   <= '0;
      mc_data_q   <= '0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      mc_cs_q    <= 1'b0;
      mc_write_q <= 1'b0;
      if (scanning && tick) pending_q <= 1'b1;
      case (state_q)
        ST_INIT: begin
          if (init_cnt_q == 5'(INIT_WRITES)) begin
            init_done_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            mc_cs_q    <= 1'b1;
            mc_write_q <= 1'b1;
            mc_addr_q  <= (init_cnt_q == 5'd0) ? PERIOD_ADDR : (init_cnt_q - 5'd1);
            mc_data_q  <= (init_cnt_q == 5'd0) ? 32'(PERIOD_INIT) : 32'd0;
            init_cnt_q <= init_cnt_q + 5'd1;
          end
        end
        ST_IDLE: begin
          if (tick || pending_q) begin
            pending_q <= pending_q & tick;
            motor_q   <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_SCAN_EN;
          end
        end
        ST_SCAN_EN: begin
          if ((eff_duty != '0) && !cur_en_q[motor_q]) begin
            mc_cs_q           <= 1'b1;
            mc_write_q        <= 1'b1;
            mc_addr_q         <= CTRL_BASE + {2'b00, motor_q};
            mc_data_q         <= 32'd1;
            cur_en_q[motor_q] <= 1'b1;
          end
          state_q <= ST_SCAN_DUTY;
        end
        ST_SCAN_DUTY: begin
          if (!step_equal) begin
            mc_cs_q             <= 1'b1;
            mc_write_q          <= 1'b1;
            mc_addr_q           <= DUTY_BASE + {2'b00, motor_q};
            mc_data_q           <= 32'(step_next);
            cur_duty_q[motor_q] <= step_next;
          end
          state_q <= ST_SCAN_DIS;
        end
        ST_SCAN_DIS: begin
          if ((cur_duty == '0) && (eff_duty == '0) && cur_en_q[motor_q]) begin
            mc_cs_q           <= 1'b1;
            mc_write_q        <= 1'b1;
            mc_addr_q         <= CTRL_BASE + {2'b00, motor_q};
            mc_data_q         <= 32'd0;
            cur_en_q[motor_q] <= 1'b0;
          end
          state_q <= ST_NEXT;
        end
        ST_NEXT: begin
          if (motor_q == 3'd7) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            motor_q <= motor_q + 3'd1;
            state_q <= ST_SCAN_EN;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign mc_chipselect = mc_cs_q;
  assign mc_write      = mc_write_q;
  assign mc_addr       = mc_addr_q;
  assign mc_writedata  = mc_data_q;
  assign init_done     = init_done_q;
  assign busy          = busy_q;
  assign fault         = fault_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_mda_motor_ramp_scheduler.sv
// Scoreboard bench: directed host writes push expected mc writes; a negedge
// monitor pops and compares each write the scheduler issues.
module tb_mda_motor_ramp_scheduler;

  localparam int RAMP_DIV   = 40;
  localparam int WDT_CYCLES = 1000;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } mcw_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        host_chipselect = 1'b0;
  logic        host_write = 1'b0;
  logic [3:0]  host_addr = '0;
  logic [31:0] host_writedata = '0;

  logic        mc_chipselect, mc_write, init_done, busy, fault, overrun;
  logic [4:0]  mc_addr;
  logic [31:0] mc_writedata;

  logic        f_mc_chipselect, f_mc_write, f_init_done, f_busy, f_fault, f_overrun;
  logic [4:0]  f_mc_addr;
  logic [31:0] f_mc_writedata;

  mcw_t sbQ[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   lastWriteCyc = 0;

  mda_motor_ramp_scheduler #(
    .DUTY_W(16), .STEP(16), .RAMP_DIV(RAMP_DIV), .WDT_CYCLES(WDT_CYCLES), .PERIOD_INIT(1000)
  ) u_dut (
    .clk(clk), .reset_n(reset_n),
    .host_chipselect(host_chipselect), .host_write(host_write),
    .host_addr(host_addr), .host_writedata(host_writedata),
    .mc_chipselect(mc_chipselect), .mc_write(mc_write),
    .mc_addr(mc_addr), .mc_writedata(mc_writedata),
    .init_done(init_done), .busy(busy), .fault(fault), .overrun(overrun)
  );

  // Short tick period so every scan outlasts a tick and overruns.
  mda_motor_ramp_scheduler #(
    .DUTY_W(16), .STEP(16), .RAMP_DIV(4), .WDT_CYCLES(100000), .PERIOD_INIT(1000)
  ) u_fast (
    .clk(clk), .reset_n(reset_n),
    .host_chipselect(host_chipselect), .host_write(host_write),
    .host_addr(host_addr), .host_writedata(host_writedata),
    .mc_chipselect(f_mc_chipselect), .mc_write(f_mc_write),
    .mc_addr(f_mc_addr), .mc_writedata(f_mc_writedata),
    .init_done(f_init_done), .busy(f_busy), .fault(f_fault), .overrun(f_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    host_chipselect = 1'b1;
    host_write      = 1'b1;
    host_addr       = a;
    host_writedata  = d;
    @(negedge clk);
    host_chipselect = 1'b0;
    host_write      = 1'b0;
  endtask

  task automatic expectWrite(input logic [4:0] a, input logic [31:0] d);
    mcw_t e;
    e.addr = a;
    e.data = d;
    sbQ.push_back(e);
  endtask

  task automatic expectInit();
    expectWrite(5'd16, 32'd1000);
    for (int a = 0; a < 16; a++) expectWrite(5'(a), 32'd0);
  endtask

  task automatic waitDrain(input string name, input int bound);
    int n = 0;
    while (sbQ.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 64'(sbQ.size()), 64'd0);
  endtask

  task automatic waitInit(input string name);
    int n = 0;
    while (!init_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 64'(init_done), 64'd1);
    checkOutput({name, "_latency"}, 64'(cyc), 64'(lastWriteCyc + 1));
  endtask

  task automatic quiet(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  always @(negedge clk) begin
    mcw_t e;
    if (reset_n && mc_write) begin
      lastWriteCyc = cyc;
      if (sbQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_write actual=(%0d,%0d) required=none", mc_addr, mc_writedata);
      end else begin
        e = sbQ.pop_front();
        checkOutput("mc_addr", 64'(mc_addr), 64'(e.addr));
        checkOutput("mc_writedata", 64'(mc_writedata), 64'(e.data));
        checkOutput("mc_chipselect", 64'(mc_chipselect), 64'd1);
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                {mc_chipselect, mc_write, mc_addr, mc_writedata, init_done, busy, fault, overrun}, 64'd0);
    checkOutput("reset_outputs_fast", {f_init_done, f_busy, f_fault, f_overrun}, 64'd0);

    expectInit();
    reset_n = 1'b1;
    waitInit("init1");
    checkOutput("fast_overrun_after_init", 64'(f_overrun), 64'd0);

    applyStimulus(4'd3, 32'h0001_0028);
    applyStimulus(4'd8, 32'h1);
    expectWrite(5'd3, 32'd1);
    expectWrite(5'd11, 32'd16);
    expectWrite(5'd11, 32'd32);
    expectWrite(5'd11, 32'd40);
    waitDrain("ramp_up_drain", 6 * RAMP_DIV);
    quiet(2 * RAMP_DIV);

    applyStimulus(4'd3, 32'h0000_0028);
    expectWrite(5'd11, 32'd24);
    expectWrite(5'd11, 32'd8);
    expectWrite(5'd11, 32'd0);
    expectWrite(5'd3, 32'd0);
    waitDrain("ramp_down_drain", 6 * RAMP_DIV);
    quiet(2 * RAMP_DIV);

    applyStimulus(4'd1, 32'h0001_0020);
    checkOutput("fault_before_wdt", 64'(fault), 64'd0);
    expectWrite(5'd1, 32'd1);
    expectWrite(5'd9, 32'd16);
    expectWrite(5'd9, 32'd32);
    waitDrain("m1_up_drain", 5 * RAMP_DIV);
    expectWrite(5'd9, 32'd16);
    expectWrite(5'd9, 32'd0);
    expectWrite(5'd1, 32'd0);
    n = 0;
    while (!fault && n < WDT_CYCLES + 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wdt_fault", 64'(fault), 64'd1);
    waitDrain("wdt_rampdown_drain", 5 * RAMP_DIV);
    applyStimulus(4'd2, 32'h0001_0050);
    checkOutput("fault_sticky", 64'(fault), 64'd1);
    checkOutput("fast_overrun_sticky", 64'(f_overrun), 64'd1);
    applyStimulus(4'd8, 32'h2);
    checkOutput("fault_cleared", 64'(fault), 64'd0);
    checkOutput("fast_overrun_cleared", 64'(f_overrun), 64'd0);
    quiet(30);
    checkOutput("fast_overrun_again", 64'(f_overrun), 64'd1);
    applyStimulus(4'd8, 32'h1);
    expectWrite(5'd1, 32'd1);
    expectWrite(5'd9, 32'd16);
    expectWrite(5'd9, 32'd32);
    waitDrain("reenable_drain", 5 * RAMP_DIV);
    quiet(2 * RAMP_DIV);

    applyStimulus(4'd5, 32'h0001_0020);
    expectWrite(5'd5, 32'd1);
    expectWrite(5'd13, 32'd16);
    expectWrite(5'd13, 32'd32);
    waitDrain("m5_up_drain", 5 * RAMP_DIV);
    applyStimulus(4'd5, 32'h0001_0000);
    n = 0;
    while (busy && n < 2 * RAMP_DIV) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!busy && n < 2 * RAMP_DIV) begin
      @(negedge clk);
      n++;
    end
    checkOutput("busy_mid_scan", 64'(busy), 64'd1);
    quiet(3);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_outputs",
                {mc_chipselect, mc_write, mc_addr, mc_writedata, init_done, busy, fault, overrun}, 64'd0);
    checkOutput("sb_empty_at_reset", 64'(sbQ.size()), 64'd0);
    expectInit();
    @(negedge clk);
    reset_n = 1'b1;
    waitInit("init2");
    applyStimulus(4'd8, 32'h1);
    applyStimulus(4'd5, 32'h0001_0010);
    expectWrite(5'd5, 32'd1);
    expectWrite(5'd13, 32'd16);
    waitDrain("post_reset_drain", 4 * RAMP_DIV);
    quiet(2 * RAMP_DIV);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
